// File: rtl/uart_rx_if.sv
// Output side of uart_rx: received byte holding register with valid/ready
// handshake plus the three single-cycle error strobes.
interface uart_rx_if;
    logic [7:0] byte_received;
    logic       valid;
    logic       ready;
    logic       framing_error;
    logic       overrun;
    logic       parity_error;

    modport master (
        output byte_received,
        output valid,
        input  ready,
        output framing_error,
        output overrun,
        output parity_error
    );

    modport slave (
        input  byte_received,
        input  valid,
        output ready,
        input  framing_error,
        input  overrun,
        input  parity_error
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default. Each start, data and stop bit is decided by
// a 2-of-3 majority vote around the bit centre. Good bytes land in a
// valid/ready holding register.
// Optional build macro UART_RX_PARITY_EN: frames become 8E1 with a PARITY
// state between DATA and STOP; without it parity_error is tied low.
//
// state      | meaning
// S_IDLE     | line idle, waiting for synced rx to fall
// S_START    | validating start bit; a high vote is a false start
// S_DATA     | shifting in 8 data bits, LSB first
// S_PARITY   | sampling the even-parity bit (parity build only)
// S_STOP     | stop-bit vote; leaves mid-bit so the next start edge is caught
// S_BREAK    | stop bit was low; wait for the line to return high
module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int SAMPLE_MID   = CLKS_PER_BIT / 2
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(SAMPLE_MID - 1);
    localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(SAMPLE_MID);
    localparam logic [CNT_W-1:0] SAMP_DEC = CNT_W'(SAMPLE_MID + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state, state_nxt;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] counter;
    logic [2:0]       bit_index;
    logic [7:0]       shift_reg;
    logic             samp_a, samp_b;
    logic             cnt_wrap, decide_now, decision;
    logic             good_frame, frame_err, pop;
`ifdef UART_RX_PARITY_EN
    logic             parity_bad, par_err;
`endif

    assign cnt_wrap   = (counter == CNT_LAST);
    assign decide_now = (counter == SAMP_DEC);
    assign decision   = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
    assign pop        = bus.valid & bus.ready;

    // Two-flop synchronizer for the asynchronous line, idling high.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and the frame-outcome strobes issued at the stop vote.
    always_comb begin
        state_nxt  = state;
        good_frame = 1'b0;
        frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err    = 1'b0;
`endif
        case (state)
            S_IDLE:  if (!rx_sync) state_nxt = S_START;
            S_START: begin
                if (decide_now && decision) state_nxt = S_IDLE;
                else if (cnt_wrap)          state_nxt = S_DATA;
            end
            S_DATA: begin
                if (cnt_wrap && bit_index == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (cnt_wrap) state_nxt = S_STOP;
`endif
            S_STOP: begin
                if (decide_now) begin
                    if (decision) begin
`ifdef UART_RX_PARITY_EN
                        par_err    = parity_bad;
                        good_frame = !parity_bad;
`else
                        good_frame = 1'b1;
`endif
                        state_nxt  = S_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: if (rx_sync) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bit timing, majority samples, bit index and data shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter   <= '0;
            bit_index <= 3'd0;
            shift_reg <= 8'h00;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_bad <= 1'b0;
`endif
        end else begin
            if (state == S_IDLE || state == S_BREAK || cnt_wrap) counter <= '0;
            else                                                  counter <= counter + 1'b1;
            if (counter == SAMP_A) samp_a <= rx_sync;
            if (counter == SAMP_B) samp_b <= rx_sync;
            if (state == S_START)                 bit_index <= 3'd0;
            else if (state == S_DATA && cnt_wrap) bit_index <= bit_index + 3'd1;
            if (state == S_DATA && decide_now) shift_reg <= {decision, shift_reg[7:1]};
`ifdef UART_RX_PARITY_EN
            if (state == S_PARITY && decide_now) parity_bad <= decision ^ (^shift_reg);
`endif
        end
    end

    // Holding register, handshake and single-cycle error strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.valid         <= 1'b0;
            bus.byte_received <= 8'h00;
            bus.framing_error <= 1'b0;
            bus.overrun       <= 1'b0;
        end else begin
            bus.framing_error <= frame_err;
            bus.overrun       <= good_frame & bus.valid & !pop;
            if (good_frame && (!bus.valid || pop)) begin
                bus.byte_received <= shift_reg;
                bus.valid         <= 1'b1;
            end else if (pop) begin
                bus.valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mismatch strobe, suppressed when the stop bit also fails.
    always_ff @(posedge clock) begin
        if (reset) bus.parity_error <= 1'b0;
        else       bus.parity_error <= par_err;
    end
`else
    assign bus.parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames generated bit by bit, received bytes and
// error strobes collected by a monitor and compared with an expected queue.
module tb_uart_rx;
    localparam int CPB = 104;
    localparam int MID = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_IDX = 10;
`else
    localparam int STOP_IDX = 9;
`endif
    // Pin edge -> 2 sync flops -> idle detect, then counter runs from 0.
    localparam int DEC_EDGES = 3 + STOP_IDX * CPB + MID + 1;
    localparam int LAT_BOUND = STOP_IDX * CPB + MID + 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock (clock),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int fe_cnt, ov_cnt, pe_cnt, valid_cycles, valid_rises, bad_pulse;
    logic prev_valid = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0, prev_pe = 1'b0;

    always @(negedge clock) begin
        #1;
        if (bus.valid && bus.ready) got_q.push_back(bus.byte_received);
        if (bus.valid) valid_cycles++;
        if (bus.valid && !prev_valid) valid_rises++;
        if (bus.framing_error) fe_cnt++;
        if (bus.overrun) ov_cnt++;
        if (bus.parity_error) pe_cnt++;
        if ((bus.framing_error && prev_fe) || (bus.overrun && prev_ov) || (bus.parity_error && prev_pe))
            bad_pulse++;
        if ((bus.framing_error || bus.parity_error) && bus.valid && !prev_valid) bad_pulse++;
        prev_valid = bus.valid;
        prev_fe    = bus.framing_error;
        prev_ov    = bus.overrun;
        prev_pe    = bus.parity_error;
    end

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        fe_cnt = 0; ov_cnt = 0; pe_cnt = 0;
        valid_cycles = 0; valid_rises = 0; bad_pulse = 0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clock);
    endtask

    // Caller is aligned to a falling clock edge; frames follow with no gap.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) rx = 1'b1;
`endif
        send_bit(stop_b);
        rx = 1'b1;
    endtask

    task automatic compare_queues(input string tag);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d bytes, want %0d", tag, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL %s_byte[%0d]: got %02h want %02h", tag, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.ready = 1'b0;
        rx = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        n_checks++;
        if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        n_checks++;
        if (bus.byte_received !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %02h want 00", bus.byte_received); end
        n_checks++;
        if (bus.framing_error !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b want 0", bus.framing_error); end
        n_checks++;
        if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b want 0", bus.overrun); end
        n_checks++;
        if (bus.parity_error !== 1'b0) begin n_fail++; $display("FAIL reset_pe: got %b want 0", bus.parity_error); end
        @(negedge clock);
        reset = 1'b0;
        idle(20);
        n_checks++;
        if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", bus.valid); end
    endtask

    task automatic test_single();
        int lat;
        clear_mon();
        bus.ready = 1'b1;
        idle(200);
        exp_q.push_back(8'hA5);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                while (bus.valid !== 1'b1 && lat < 3000) begin
                    @(posedge clock);
                    #1;
                    lat++;
                end
            end
        join
        idle(50);
        compare_queues("single");
        n_checks++;
        if (lat >= 3000 || lat - 1 > LAT_BOUND) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles want <= %0d", lat - 1, LAT_BOUND);
        end
        n_checks++;
        if (valid_cycles !== 1) begin n_fail++; $display("FAIL single_valid_width: got %0d want 1", valid_cycles); end
        n_checks++;
        if (fe_cnt + ov_cnt + pe_cnt !== 0) begin
            n_fail++;
            $display("FAIL single_errors: got fe=%0d ov=%0d pe=%0d want 0", fe_cnt, ov_cnt, pe_cnt);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        bus.ready = 1'b1;
        idle(50);
        rx = 1'b0;
        repeat (20) @(negedge clock);
        idle(300);
        n_checks++;
        if (valid_rises !== 0 || fe_cnt + ov_cnt + pe_cnt !== 0) begin
            n_fail++;
            $display("FAIL glitch_quiet: got valid_rises=%0d errors=%0d want 0", valid_rises, fe_cnt + ov_cnt + pe_cnt);
        end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(100);
        compare_queues("glitch");
    endtask

    task automatic test_framing();
        clear_mon();
        bus.ready = 1'b1;
        idle(50);
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (300) @(negedge clock);
        idle(200);
        n_checks++;
        if (fe_cnt !== 1) begin n_fail++; $display("FAIL framing_pulse: got %0d want 1", fe_cnt); end
        n_checks++;
        if (valid_rises !== 0 || pe_cnt !== 0) begin
            n_fail++;
            $display("FAIL framing_no_valid: got valid_rises=%0d pe=%0d want 0", valid_rises, pe_cnt);
        end
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0);
        idle(100);
        compare_queues("framing_next");
        n_checks++;
        if (bad_pulse !== 0) begin n_fail++; $display("FAIL framing_pulse_shape: got %0d bad want 0", bad_pulse); end
    endtask

    task automatic test_overrun();
        clear_mon();
        bus.ready = 1'b0;
        idle(50);
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        idle(100);
        n_checks++;
        if (bus.valid !== 1'b1 || bus.byte_received !== 8'h01) begin
            n_fail++;
            $display("FAIL overrun_hold: got valid=%b byte=%02h want 1/01", bus.valid, bus.byte_received);
        end
        n_checks++;
        if (ov_cnt !== 1) begin n_fail++; $display("FAIL overrun_pulse: got %0d want 1", ov_cnt); end
        bus.ready = 1'b1;
        @(negedge clock);
        bus.ready = 1'b0;
        idle(5);
        n_checks++;
        if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL overrun_pop: got valid=%b want 0", bus.valid); end
        exp_q.push_back(8'h01);
        compare_queues("overrun");
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic [7:0] x, y;
        clear_mon();
        bus.ready = 1'b1;
        idle(50);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80);
        for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom));
        for (int i = 0; i < exp_q.size(); i++) begin
            d = exp_q[i];
            send_frame(d, 1'b1, 1'b0);
        end
        idle(100);
        compare_queues("b2b");
        n_checks++;
        if (fe_cnt + ov_cnt + pe_cnt !== 0 || valid_rises !== 6) begin
            n_fail++;
            $display("FAIL b2b_events: got errors=%0d valid_rises=%0d want 0/6", fe_cnt + ov_cnt + pe_cnt, valid_rises);
        end

        clear_mon();
        x = 8'($urandom);
        y = 8'($urandom);
        bus.ready = 1'b0;
        send_frame(x, 1'b1, 1'b0);
        fork
            send_frame(y, 1'b1, 1'b0);
            begin
                repeat (DEC_EDGES - 1) @(posedge clock);
                @(negedge clock);
                bus.ready = 1'b1;
                @(negedge clock);
                bus.ready = 1'b0;
            end
        join
        idle(50);
        n_checks++;
        if (ov_cnt !== 0) begin n_fail++; $display("FAIL pop_at_decision_overrun: got %0d want 0", ov_cnt); end
        n_checks++;
        if (bus.valid !== 1'b1 || bus.byte_received !== y) begin
            n_fail++;
            $display("FAIL pop_at_decision_hold: got valid=%b byte=%02h want 1/%02h", bus.valid, bus.byte_received, y);
        end
        bus.ready = 1'b1;
        idle(5);
        exp_q.push_back(x);
        exp_q.push_back(y);
        compare_queues("pop_at_decision");
    endtask

    task automatic test_random();
        logic [7:0] d;
        clear_mon();
        bus.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            idle($urandom_range(0, 200));
            send_frame(d, 1'b1, 1'b0);
        end
        idle(100);
        compare_queues("random");
        n_checks++;
        if (fe_cnt + ov_cnt + pe_cnt + bad_pulse !== 0) begin
            n_fail++;
            $display("FAIL random_errors: got %0d want 0", fe_cnt + ov_cnt + pe_cnt + bad_pulse);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        bus.ready = 1'b1;
        idle(50);
        fork
            send_frame(8'hF0, 1'b1, 1'b1);
            begin
                repeat (4 * CPB + 90) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
        join
        idle(1100);
        n_checks++;
        if (valid_rises !== 0 || fe_cnt + pe_cnt !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got valid_rises=%0d errors=%0d want 0", valid_rises, fe_cnt + pe_cnt);
        end
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(100);
        compare_queues("abort_next");
        n_checks++;
        if (valid_rises !== 1) begin n_fail++; $display("FAIL abort_valid_count: got %0d want 1", valid_rises); end
`ifdef UART_RX_PARITY_EN
        send_frame(8'h7E, 1'b1, 1'b1);
        idle(100);
        n_checks++;
        if (pe_cnt !== 1) begin n_fail++; $display("FAIL parity_pulse: got %0d want 1", pe_cnt); end
        n_checks++;
        if (valid_rises !== 1 || got_q.size() !== 1) begin
            n_fail++;
            $display("FAIL parity_drop: got valid_rises=%0d bytes=%0d want 1/1", valid_rises, got_q.size());
        end
`endif
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
